hub75_slice_scheduler: RTL

Rotational slice scheduler for the HUB75 column driver in the persistence-of-vision display. It measures the rotor period from the hall-sensor index pulse and divides each revolution into ROTATIONAL_RES angular slices. For each slice it reads SCAN_RATE scan lines from the framebuffer and feeds them to the HUB75 output stage over its tvalid/tready handshake. It also reports spin status and slice overruns.

---
 rtl/hub75_slice_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/hub75_slice_scheduler.sv
// rtl/hub75_slice_scheduler.sv - rotor period measurement and per-slice scan-line fetch scheduler
// Splits each revolution into angular slices and streams SCAN_RATE framebuffer beats per slice.
module hub75_slice_scheduler #(
    parameter int ROTATIONAL_RES = 180,
    parameter int SCAN_RATE      = 32,
    parameter int PERIOD_W       = 24,
    parameter int MIN_PERIOD     = 1000,
    parameter int RD_LATENCY     = 2
) (
    input  logic                                                  clk_in,
    input  logic                                                  rst_n_in,
    input  logic                                                  index_in,
    output logic                                                  fb_rd_en,
    output logic [$clog2(ROTATIONAL_RES)+$clog2(SCAN_RATE)-1:0]   fb_addr,
    output logic [$clog2(ROTATIONAL_RES)-1:0]                     theta_out,
    output logic [$clog2(SCAN_RATE)-1:0]                          col_index,
    output logic                                                  tvalid,
    input  logic                                                  tready,
    output logic                                                  spinning,
    output logic [PERIOD_W-1:0]                                   period_out,
    output logic [15:0]                                           overrun_count
);

    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int SW = $clog2(SCAN_RATE);
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [PERIOD_W-1:0] CNT_MAX    = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W:0]   MIN_W      = (PERIOD_W+1)'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   RES_W      = (PERIOD_W+1)'(ROTATIONAL_RES);
    localparam logic [TW-1:0]       THETA_LAST = TW'(ROTATIONAL_RES - 1);
    localparam logic [SW-1:0]       SCAN_LAST  = SW'(SCAN_RATE - 1);
    localparam logic [WW-1:0]       WAIT_LAST  = WW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_VALID, ST_DONE} state_t;

    // index synchronizer and edge register
    logic [1:0]          sync_q;
    logic                idx_q;
    logic                rise;

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W:0]   cnt_inc;
    logic [PERIOD_W-1:0] cnt_sat;
    logic [PERIOD_W-1:0] acc;
    logic [PERIOD_W:0]   acc_sum;
    logic [PERIOD_W-1:0] acc_sub;
    logic [TW-1:0]       theta;
    logic                armed;

    logic                timeout;
    logic                accept;
    logic                spin_nxt;
    logic                slice_start;
    logic [TW-1:0]       theta_nxt;
    logic [PERIOD_W-1:0] acc_nxt;

    state_t              state;
    logic [SW-1:0]       scan;
    logic [TW-1:0]       slice_theta;
    logic [WW-1:0]       wait_cnt;
    logic                rd_pending;
    logic                pend_valid;
    logic [TW-1:0]       pend_theta;
    logic [TW-1:0]       restart_theta;

    assign rise      = sync_q[1] & ~idx_q;
    assign cnt_inc   = {1'b0, cnt} + {{PERIOD_W{1'b0}}, 1'b1};
    assign cnt_sat   = (cnt == CNT_MAX) ? CNT_MAX : cnt_inc[PERIOD_W-1:0];
    assign acc_sum   = {1'b0, acc} + RES_W;
    assign acc_sub   = acc_sum[PERIOD_W-1:0] - period_out;
    assign theta_out = theta;
    assign col_index = scan;

    always_comb begin
        timeout     = (cnt == CNT_MAX);
        accept      = rise && ((cnt_inc >= MIN_W) || !spinning);
        spin_nxt    = spinning;
        theta_nxt   = theta;
        acc_nxt     = acc;
        slice_start = 1'b0;
        if (accept) begin
            theta_nxt   = '0;
            acc_nxt     = '0;
            slice_start = 1'b1;
            spin_nxt    = armed && !timeout;
        end else if (timeout) begin
            spin_nxt = 1'b0;
        end else if (spinning) begin
            // accumulate RES per cycle; crossing period_out marks one slice boundary
            if (acc_sum >= {1'b0, period_out}) begin
                acc_nxt = acc_sub;
                if (theta != THETA_LAST) begin
                    theta_nxt   = theta + 1'b1;
                    slice_start = 1'b1;
                end
            end else begin
                acc_nxt = acc_sum[PERIOD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q     <= '0;
            idx_q      <= 1'b0;
            cnt        <= '0;
            period_out <= '0;
            acc        <= '0;
            theta      <= '0;
            spinning   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], index_in};
            idx_q    <= sync_q[1];
            spinning <= spin_nxt;
            acc      <= acc_nxt;
            theta    <= theta_nxt;
            if (accept) begin
                cnt        <= '0;
                period_out <= cnt_sat;
                armed      <= 1'b1;
            end else if (timeout) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt_inc[PERIOD_W-1:0];
            end
        end
    end

    assign restart_theta = slice_start ? theta_nxt : pend_theta;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ST_IDLE;
            scan          <= '0;
            slice_theta   <= '0;
            wait_cnt      <= '0;
            rd_pending    <= 1'b0;
            pend_valid    <= 1'b0;
            pend_theta    <= '0;
            fb_rd_en      <= 1'b0;
            fb_addr       <= '0;
            tvalid        <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (slice_start && (state == ST_FETCH || state == ST_VALID) &&
                overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
            if (state != ST_VALID && !spin_nxt) begin
                state      <= ST_IDLE;
                fb_rd_en   <= 1'b0;
                rd_pending <= 1'b0;
            end else if (state != ST_VALID && slice_start) begin
                state       <= ST_FETCH;
                slice_theta <= theta_nxt;
                scan        <= '0;
                fb_addr     <= {theta_nxt, {SW{1'b0}}};
                fb_rd_en    <= 1'b1;
                wait_cnt    <= '0;
                rd_pending  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        fb_rd_en <= 1'b0;
                    end
                    ST_FETCH: begin
                        fb_rd_en <= 1'b0;
                        if (rd_pending) begin
                            fb_rd_en   <= 1'b1;
                            rd_pending <= 1'b0;
                            wait_cnt   <= '0;
                        end else if (wait_cnt == WAIT_LAST) begin
                            state  <= ST_VALID;
                            tvalid <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_VALID: begin
                        // a beat on the bus is never withdrawn; pending starts wait for the handshake
                        if (tready) begin
                            tvalid     <= 1'b0;
                            pend_valid <= 1'b0;
                            if (!spin_nxt) begin
                                state <= ST_IDLE;
                            end else if (slice_start || pend_valid) begin
                                state       <= ST_FETCH;
                                slice_theta <= restart_theta;
                                scan        <= '0;
                                fb_addr     <= {restart_theta, {SW{1'b0}}};
                                rd_pending  <= 1'b1;
                            end else if (scan == SCAN_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                state      <= ST_FETCH;
                                scan       <= scan + 1'b1;
                                fb_addr    <= {slice_theta, scan + 1'b1};
                                rd_pending <= 1'b1;
                            end
                        end else if (slice_start) begin
                            pend_valid <= 1'b1;
                            pend_theta <= theta_nxt;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
